eth_commit_ctrl: RTL and testbench

//  Commit controller between the Ethernet receive datapath and the manta bus write port.

---
 rtl/eth_commit_ctrl.sv | 151 +++++++++++++++
 tb/tb_eth_commit_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_commit_ctrl.sv
// Holds the {addr,data} words of one received frame until the CRC verdict arrives, then
// either replays them as back-to-back bus writes or throws the whole frame away.
module eth_commit_ctrl #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_v,
  input  logic        axiiv,
  input  logic [31:0] axiid,
  input  logic        done,
  input  logic        kill,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_rw,
  output logic        bus_valid,
  output logic [15:0] commit_cnt,
  output logic [15:0] drop_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StCollect, StWait, StDrain} state_e;

  state_e      r_state;
  logic        r_frame_q;
  logic        r_ovf;
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [TW-1:0] r_timer;
  logic [31:0] r_buf [DEPTH];
  logic [15:0] r_addr, r_wdata, r_commit, r_drop;
  logic        r_valid, r_rw;

  logic          w_start, w_accept, w_full, w_store, w_ovf_nx, w_verdict, w_good;
  logic          w_timeout, w_discard, w_ign;
  logic [CW-1:0] w_cnt_nx;
  logic [31:0]   w_first;
  logic [1:0]    w_drop_inc;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    w_start    = frame_v & ~r_frame_q;
    w_accept   = (r_state == StCollect) || (r_state == StWait);
    w_full     = (r_wr_ptr == CW'(DEPTH));
    w_store    = w_accept & axiiv & ~w_full;
    w_ovf_nx   = r_ovf | (w_accept & axiiv & w_full);
    w_cnt_nx   = r_wr_ptr + CW'(w_store);
    w_verdict  = done | kill;
    w_good     = done & ~kill & ~w_ovf_nx;
    // A word arriving with the verdict on an empty buffer is itself the first write.
    w_first    = (r_wr_ptr == CW'(0)) ? axiid : r_buf[0];
    w_timeout  = (r_state == StWait) && (r_timer == TW'(TIMEOUT - 1)) && !w_verdict;
    w_discard  = w_accept & ((w_verdict & ~w_good) | w_timeout);
    w_ign      = w_start & (r_state != StIdle);
    w_drop_inc = {1'b0, w_discard} + {1'b0, w_ign};
  end

  always_ff @(posedge clk) begin
    if (w_store) r_buf[r_wr_ptr[PW-1:0]] <= axiid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_frame_q <= 1'b0;
      r_ovf     <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_timer   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_valid   <= 1'b0;
      r_rw      <= 1'b0;
      r_commit  <= '0;
      r_drop    <= '0;
    end else begin
      r_frame_q <= frame_v;
      r_valid   <= 1'b0;
      r_rw      <= 1'b0;
      r_drop    <= sat_add(r_drop, w_drop_inc);
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state  <= StCollect;
            r_wr_ptr <= '0;
            r_ovf    <= 1'b0;
            r_timer  <= '0;
          end
        end
        StCollect, StWait: begin
          r_wr_ptr <= w_cnt_nx;
          r_ovf    <= w_ovf_nx;
          if (r_state == StWait) r_timer <= r_timer + TW'(1);
          if (w_verdict) begin
            r_state <= StIdle;
            if (w_good) begin
              if (w_cnt_nx == CW'(0)) begin
                r_commit <= sat_add(r_commit, 2'd1);
              end else begin
                r_valid <= 1'b1;
                r_rw    <= 1'b1;
                r_addr  <= w_first[31:16];
                r_wdata <= w_first[15:0];
                if (w_cnt_nx == CW'(1)) begin
                  r_commit <= sat_add(r_commit, 2'd1);
                end else begin
                  r_state  <= StDrain;
                  r_rd_ptr <= CW'(1);
                end
              end
            end
          end else if (w_timeout) begin
            r_state <= StIdle;
          end else if ((r_state == StCollect) && !frame_v) begin
            r_state <= StWait;
            r_timer <= '0;
          end
        end
        StDrain: begin
          r_valid <= 1'b1;
          r_rw    <= 1'b1;
          r_addr  <= r_buf[r_rd_ptr[PW-1:0]][31:16];
          r_wdata <= r_buf[r_rd_ptr[PW-1:0]][15:0];
          if (r_rd_ptr == r_wr_ptr - CW'(1)) begin
            r_state  <= StIdle;
            r_commit <= sat_add(r_commit, 2'd1);
          end else begin
            r_rd_ptr <= r_rd_ptr + CW'(1);
          end
        end
      endcase
    end
  end

  assign bus_addr   = r_addr;
  assign bus_wdata  = r_wdata;
  assign bus_rw     = r_rw;
  assign bus_valid  = r_valid;
  assign commit_cnt = r_commit;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_eth_commit_ctrl.sv
// Directed and randomized frames for eth_commit_ctrl, checked every cycle against a
// queue-based frame model.
module tb_eth_commit_ctrl;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 64;

  localparam int M_IDLE = 0, M_COLLECT = 1, M_WAIT = 2, M_DRAIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, frame_v = 1'b0, axiiv = 1'b0, done = 1'b0, kill = 1'b0;
  logic [31:0] axiid = '0;
  logic [15:0] bus_addr, bus_wdata, commit_cnt, drop_cnt;
  logic bus_rw, bus_valid;

  eth_commit_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .frame_v(frame_v), .axiiv(axiiv), .axiid(axiid),
    .done(done), .kill(kill), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rw(bus_rw), .bus_valid(bus_valid), .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, n_strobes = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: words of the pending frame and words still to be written out.
  int          m_mode = M_IDLE;
  int          m_timer = 0;
  bit          m_ovf = 0, m_fq = 0;
  logic [31:0] m_words[$];
  logic [31:0] m_out[$];
  logic [15:0] e_addr = '0, e_wdata = '0, e_commit = '0, e_drop = '0;
  bit          e_valid = 0;

  function automatic logic [15:0] inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  task automatic emit(input logic [31:0] w);
    e_valid = 1;
    e_addr  = w[31:16];
    e_wdata = w[15:0];
  endtask

  task automatic model_step();
    bit start, was_idle, tout;
    if (rst) begin
      m_mode = M_IDLE; m_timer = 0; m_ovf = 0; m_fq = 0;
      m_words.delete(); m_out.delete();
      e_addr = '0; e_wdata = '0; e_commit = '0; e_drop = '0; e_valid = 0;
      return;
    end
    start    = frame_v && !m_fq;
    m_fq     = frame_v;
    was_idle = (m_mode == M_IDLE);
    e_valid  = 0;
    case (m_mode)
      M_DRAIN: begin
        emit(m_out.pop_front());
        if (m_out.size() == 0) begin m_mode = M_IDLE; e_commit = inc16(e_commit); end
      end
      M_COLLECT, M_WAIT: begin
        if (axiiv) begin
          if (m_words.size() < DEPTH) m_words.push_back(axiid);
          else m_ovf = 1;
        end
        tout = (m_mode == M_WAIT) && (m_timer == TIMEOUT - 1) && !done && !kill;
        m_timer++;
        if (kill || (done && m_ovf)) begin
          m_mode = M_IDLE; e_drop = inc16(e_drop);
        end else if (done) begin
          m_mode = M_IDLE;
          m_out = m_words;
          if (m_out.size() == 0) e_commit = inc16(e_commit);
          else begin
            emit(m_out.pop_front());
            if (m_out.size() == 0) e_commit = inc16(e_commit);
            else m_mode = M_DRAIN;
          end
        end else if (tout) begin
          m_mode = M_IDLE; e_drop = inc16(e_drop);
        end else if (m_mode == M_COLLECT && !frame_v) begin
          m_mode = M_WAIT; m_timer = 0;
        end
      end
      default: begin
        if (start) begin m_mode = M_COLLECT; m_words.delete(); m_ovf = 0; m_timer = 0; end
      end
    endcase
    if (start && !was_idle) e_drop = inc16(e_drop);
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check_eq("bus_valid", bus_valid, e_valid);
    check_eq("bus_rw", bus_rw, e_valid);
    check_eq("bus_addr", bus_addr, e_addr);
    check_eq("bus_wdata", bus_wdata, e_wdata);
    check_eq("commit_cnt", commit_cnt, e_commit);
    check_eq("drop_cnt", drop_cnt, e_drop);
    if (bus_valid) n_strobes++;
  end

  task automatic drive(input bit fv, input bit v, input logic [31:0] d, input bit dn,
                       input bit kl, input bit r);
    @(negedge clk);
    frame_v = fv; axiiv = v; axiid = d; done = dn; kill = kl; rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 32'h0, 0, 0, 1);
    drive(0, 0, 32'h0, 0, 0, 1);
    idle(1);
  endtask

  task automatic send_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) drive(1, 1, base + 32'h0001_0001 * i, 0, 0, 0);
  endtask

  initial begin
    int base;
    do_reset();
    check_eq("reset_valid", bus_valid, 0);
    check_eq("reset_commit", commit_cnt, 0);
    check_eq("reset_drop", drop_cnt, 0);

    // Good three-word frame.
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h0001AAAA, 0, 0, 0);
    drive(1, 1, 32'h0002BBBB, 0, 0, 0);
    drive(1, 1, 32'h0003CCCC, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    base = n_strobes;
    idle(6);
    check_eq("t1_strobes", n_strobes - base, 3);
    check_eq("t1_commit", commit_cnt, 1);

    // Same frame, bad CRC.
    do_reset();
    base = n_strobes;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h0001AAAA, 0, 0, 0);
    drive(1, 1, 32'h0002BBBB, 0, 0, 0);
    drive(1, 1, 32'h0003CCCC, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    idle(6);
    check_eq("t2_strobes", n_strobes - base, 0);
    check_eq("t2_drop", drop_cnt, 1);
    check_eq("t2_commit", commit_cnt, 0);

    // Overflow by one word, then a good two-word frame.
    do_reset();
    base = n_strobes;
    drive(1, 0, 0, 0, 0, 0);
    send_words(DEPTH + 1, 32'h0010_0100);
    drive(0, 0, 0, 1, 0, 0);
    idle(4);
    check_eq("t3_ovf_strobes", n_strobes - base, 0);
    check_eq("t3_ovf_drop", drop_cnt, 1);
    drive(1, 0, 0, 0, 0, 0);
    send_words(2, 32'h0020_0200);
    drive(0, 0, 0, 1, 0, 0);
    idle(5);
    check_eq("t3_strobes", n_strobes - base, 2);
    check_eq("t3_commit", commit_cnt, 1);

    // Timeout, then a late verdict that must be ignored.
    do_reset();
    base = n_strobes;
    drive(1, 0, 0, 0, 0, 0);
    send_words(2, 32'h0030_0300);
    idle(TIMEOUT + 6);
    check_eq("t4_drop", drop_cnt, 1);
    idle(4);
    drive(0, 0, 0, 1, 0, 0);
    idle(6);
    check_eq("t4_late_drop", drop_cnt, 1);
    check_eq("t4_late_commit", commit_cnt, 0);
    check_eq("t4_strobes", n_strobes - base, 0);

    // Word arriving with done belongs to the frame; done+kill discards.
    do_reset();
    base = n_strobes;
    drive(1, 0, 0, 0, 0, 0);
    send_words(3, 32'h0040_0400);
    drive(1, 1, 32'h0044_0444, 1, 0, 0);
    idle(7);
    check_eq("t5_strobes", n_strobes - base, 4);
    check_eq("t5_commit", commit_cnt, 1);
    drive(1, 0, 0, 0, 0, 0);
    send_words(2, 32'h0050_0500);
    drive(0, 0, 0, 1, 1, 0);
    idle(5);
    check_eq("t5_both_drop", drop_cnt, 1);
    check_eq("t5_both_strobes", n_strobes - base, 4);

    // Reset in the middle of a drain.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    send_words(4, 32'h0060_0600);
    drive(0, 0, 0, 1, 0, 0);
    base = n_strobes;
    idle(1);
    drive(0, 0, 0, 0, 0, 1);
    idle(6);
    check_eq("t6_strobes", n_strobes - base, 2);
    check_eq("t6_commit", commit_cnt, 0);
    check_eq("t6_drop", drop_cnt, 0);

    // Randomized frames with varied lengths, lags, verdict timing and restarts.
    for (int e = 0; e < 40; e++) begin
      int len, nw, lag, vc, kind, rs;
      bit restart, fv, v, dn, kl;
      len     = $urandom_range(2, 12);
      nw      = $urandom_range(0, DEPTH + 2);
      lag     = $urandom_range(0, 3);
      vc      = ($urandom_range(0, 9) < 2) ? -1 : len + $urandom_range(0, 8) - 1;
      kind    = $urandom_range(0, 5);
      restart = ($urandom_range(0, 3) == 0);
      rs      = (vc < 0) ? len + 5 : vc + 2;
      for (int i = 0; i < len + 100; i++) begin
        fv = (i >= 1 && i <= len) || (restart && i >= rs && i < rs + 2);
        v  = (i >= 2 + lag) && (i < 2 + lag + nw);
        dn = (i == vc) && (kind != 0);
        kl = (i == vc) && (kind <= 1);
        drive(fv, v, $urandom, dn, kl, 0);
      end
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
